regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file for the pipelined core, replacing the fixed 32x32, 2-read/1-write file.
- Adds a second write port, an optional write-to-read bypass, an optional hardwired zero register and a per-register pending-write scoreboard.
- Decode reads operands and busy flags from it.
- Writeback (port 0) and the long-latency unit (port 1) write it.

---
 rtl/regfile_mp_sb.sv | 149 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass, zero register and busy scoreboard
//
// Purpose:
//   Register file shared by decode (reads operands and busy flags), writeback
//   (write port 0) and the long-latency unit (write port 1). A per-register busy
//   bit tracks whether an issued producer still owes the register a value.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   we0        - write enable, port 0 (writeback)
//   waddr0     - write address, port 0
//   wdata0     - write data, port 0
//   we1        - write enable, port 1 (long-latency unit; wins on address clash)
//   waddr1     - write address, port 1
//   wdata1     - write data, port 1
//   raddr      - NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata      - NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rbusy      - per read port: addressed register has a pending producer
//   alloc      - mark alloc_addr pending (producer issued)
//   alloc_addr - register to mark pending
//   flush      - clear every busy bit
//   busy_any   - OR of the registered busy bits

module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     alloc,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     flush,
    output logic                     busy_any
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_REGS-1:0]             busy_d;

    // Effective write strobes: writes to the hardwired zero register vanish
    // here, so neither storage, scoreboard nor bypass ever sees them.
    logic wr0_en;
    logic wr1_en;

    assign wr0_en = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_en = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Storage next state: port 1 is applied last so it wins an address clash.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr1_en && (waddr1 == ADDR_W'(r))) begin
                regs_d[r] = wdata1;
            end else if (wr0_en && (waddr0 == ADDR_W'(r))) begin
                regs_d[r] = wdata0;
            end
        end
    end

    // Scoreboard next state. Priority: flush, then alloc, then a completing
    // write. Alloc beating a same-cycle write lets a new producer be issued in
    // the very cycle the previous one retires.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (alloc && (alloc_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_en && (waddr0 == ADDR_W'(r))) ||
                         (wr1_en && (waddr1 == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Registered-state OR only; deliberately not bypassed so it lags a
    // same-cycle write by one cycle.
    assign busy_any = |busy_q;

    // Read ports: combinational lookup with optional same-cycle forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        logic              alloc_hit;
        logic [DATA_W-1:0] val;
        logic              bsy;

        assign ra        = raddr[k*ADDR_W +: ADDR_W];
        assign hit0      = (BYPASS != 0) && wr0_en && (waddr0 == ra);
        assign hit1      = (BYPASS != 0) && wr1_en && (waddr1 == ra);
        assign alloc_hit = alloc && (alloc_addr == ra);

        always_comb begin
            val = regs_q[ra];
            bsy = busy_q[ra];
            if (hit1) begin
                val = wdata1;
            end else if (hit0) begin
                val = wdata0;
            end
            // A forwarded value satisfies the consumer unless a new producer
            // is claiming the register in the same cycle.
            if ((hit0 || hit1) && !alloc_hit) begin
                bsy = 1'b0;
            end
            // Reset gating covers the bypass path, which is not held by the
            // asynchronous clear of the storage.
            if (rst || ((ZERO_REG != 0) && (ra == '0))) begin
                val = '0;
                bsy = 1'b0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = val;
        assign rbusy[k]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        alloc;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic        busy_any;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [31:0] mem [32];
    logic [31:0] mbusy;

    assign raddr = {ra1, ra0};

    regfile_mp_sb dut (
        .clk        (clk),
        .rst        (rst),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .alloc      (alloc),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_any   (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        alloc;
        logic [4:0]  aa;
        logic        flush;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        eany;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input bit w0, input int a0, input logic [31:0] d0,
                                input bit w1, input int a1, input logic [31:0] d1,
                                input bit al, input int aa, input bit fl,
                                input int r0, input int r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input bit eany);
        vec_t v;
        v.we0 = w0;  v.wa0 = 5'(a0); v.wd0 = d0;
        v.we1 = w1;  v.wa1 = 5'(a1); v.wd1 = d1;
        v.alloc = al; v.aa = 5'(aa); v.flush = fl;
        v.r0 = 5'(r0); v.r1 = 5'(r1);
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.eany = eany;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: read value as seen by a consumer this cycle.
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        bit wr;
        if (a == 5'd0) return 1'b0;
        wr = (we0 && waddr0 == a) || (we1 && waddr1 == a);
        if (wr && !(alloc && alloc_addr == a)) return 1'b0;
        return mbusy[a];
    endfunction

    // Model: commit this cycle's events.
    task automatic m_update();
        if (we0 && waddr0 != 5'd0) mem[waddr0] = wdata0;
        if (we1 && waddr1 != 5'd0) mem[waddr1] = wdata1;
        if (flush) begin
            mbusy = '0;
        end else begin
            if (we0) mbusy[waddr0] = 1'b0;
            if (we1) mbusy[waddr1] = 1'b0;
            if (alloc) mbusy[alloc_addr] = 1'b1;
        end
        mbusy[0] = 1'b0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mbusy = '0;
    endtask

    task automatic idle_inputs();
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        alloc = 0; alloc_addr = 0; flush = 0;
    endtask

    // Check outputs against the model mid-cycle, then advance one clock.
    task automatic model_cycle(input string tag);
        @(negedge clk);
        check({tag, ".rdata0"}, rdata[31:0], m_read(ra0));
        check({tag, ".rdata1"}, rdata[63:32], m_read(ra1));
        check({tag, ".rbusy"}, {30'h0, rbusy}, {30'h0, m_rbusy(ra1), m_rbusy(ra0)});
        check({tag, ".busy_any"}, {31'h0, busy_any}, {31'h0, |mbusy});
        m_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        idle_inputs();
        ra0 = 5'd3; ra1 = 5'd7;
        m_reset();

        tbl[0]  = mk(1, 5, 32'h11111111, 1, 9, 32'h22222222, 0, 0, 0, 5, 9, 32'h11111111, 32'h22222222, 2'b00, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 9, 32'h11111111, 32'h22222222, 2'b00, 0);
        tbl[2]  = mk(1, 4, 32'hAAAA0000, 1, 4, 32'h0000BBBB, 0, 0, 0, 4, 5, 32'h0000BBBB, 32'h11111111, 2'b00, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h0000BBBB, 32'h0000BBBB, 2'b00, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 12, 0, 12, 9, 32'h0, 32'h22222222, 2'b00, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 9, 32'h0, 32'h22222222, 2'b01, 1);
        tbl[8]  = mk(1, 12, 32'h1234, 0, 0, 0, 0, 0, 0, 12, 12, 32'h1234, 32'h1234, 2'b00, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'h1234, 32'h1234, 2'b00, 0);
        tbl[10] = mk(0, 0, 0, 1, 6, 32'hCAFE0006, 1, 6, 0, 6, 7, 32'hCAFE0006, 32'h0, 2'b00, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 7, 32'hCAFE0006, 32'h0, 2'b01, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 8, 1, 8, 6, 32'h0, 32'hCAFE0006, 2'b10, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 6, 32'h0, 32'hCAFE0006, 2'b00, 0);
        tbl[14] = mk(1, 7, 32'h77, 0, 0, 0, 1, 3, 0, 3, 7, 32'h0, 32'h77, 2'b00, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 3, 7, 32'h0, 32'h77, 2'b01, 1);

        // Outputs held at zero while reset is asserted from power-up.
        #2;
        check("por.rdata0", rdata[31:0], 32'h0);
        check("por.rdata1", rdata[63:32], 32'h0);
        check("por.rbusy", {30'h0, rbusy}, 32'h0);
        check("por.busy_any", {31'h0, busy_any}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
            we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
            alloc = tbl[i].alloc; alloc_addr = tbl[i].aa; flush = tbl[i].flush;
            ra0 = tbl[i].r0; ra1 = tbl[i].r1;
            @(negedge clk);
            check($sformatf("vec%0d.rdata0", i), rdata[31:0], tbl[i].e0);
            check($sformatf("vec%0d.rdata1", i), rdata[63:32], tbl[i].e1);
            check($sformatf("vec%0d.rbusy", i), {30'h0, rbusy}, {30'h0, tbl[i].eb});
            check($sformatf("vec%0d.busy_any", i), {31'h0, busy_any}, {31'h0, tbl[i].eany});
            m_update();
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model; addresses mostly
        // drawn from a small window so clashes and bypass hits are frequent.
        for (int i = 0; i < 400; i++) begin
            we0        = 1'($urandom_range(0, 1));
            waddr0     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata0     = $urandom;
            we1        = 1'($urandom_range(0, 1));
            waddr1     = 5'($urandom_range(0, 7));
            wdata1     = $urandom;
            alloc      = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            ra0        = 5'($urandom_range(0, 7));
            ra1        = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            model_cycle($sformatf("rnd%0d", i));
        end

        // Reset mid-operation with r3 and r7 holding data and r3 busy.
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33333333;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h77777777;
        alloc = 1; alloc_addr = 5'd3; flush = 0;
        ra0 = 5'd3; ra1 = 5'd7;
        model_cycle("prerst_wr");
        idle_inputs();
        model_cycle("prerst_rd");
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h55555555;
        alloc = 1; alloc_addr = 5'd7;
        rst = 1'b1;
        #2;
        check("rst.rdata0", rdata[31:0], 32'h0);
        check("rst.rdata1", rdata[63:32], 32'h0);
        check("rst.rbusy", {30'h0, rbusy}, 32'h0);
        check("rst.busy_any", {31'h0, busy_any}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold.rdata0", rdata[31:0], 32'h0);
        check("rst_hold.busy_any", {31'h0, busy_any}, 32'h0);
        idle_inputs();
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        check("postrst.r3", rdata[31:0], 32'h0);
        check("postrst.r7", rdata[63:32], 32'h0);
        check("postrst.rbusy", {30'h0, rbusy}, 32'h0);
        @(posedge clk);
        #1;
        model_cycle("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
